// File: rtl/reg_func_sequencer_if.sv
// Instruction channel and register-bank command bus between an instruction
// source (master) and the func-code sequencer (slave).
interface reg_func_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
);
    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both 1; the master holds its fields stable until then.
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [WIDTH-1:0] instr_operand;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       func_x;
    logic [2:0]       func_y;
    logic [2:0]       func_z;
    logic [WIDTH-1:0] data_out;
    logic             done;
    logic             err;
    logic [1:0]       dbg_state;

    modport master (
        output instr_valid, instr_op, instr_operand, instr_count,
        input  instr_ready, func_x, func_y, func_z, data_out, done, err, dbg_state
    );

    modport slave (
        input  instr_valid, instr_op, instr_operand, instr_count,
        output instr_ready, func_x, func_y, func_z, data_out, done, err, dbg_state
    );
endinterface

// File: rtl/reg_func_sequencer.sv
// Turns one accepted instruction into per-cycle func codes for the X/Y/Z
// registers; multi-step shifts expand into consecutive SL/SR cycles.
module reg_func_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    reg_func_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    localparam logic [2:0] F_CLEAR = 3'b000;
    localparam logic [2:0] F_LOAD  = 3'b001;
    localparam logic [2:0] F_HOLD  = 3'b010;
    localparam logic [2:0] F_SL    = 3'b011;
    localparam logic [2:0] F_SR    = 3'b100;

    logic [1:0]       state_q, state_d;
    logic [2:0]       fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    always_comb begin
        state_d = state_q;
        fx_d    = F_HOLD;
        fy_d    = F_HOLD;
        fz_d    = F_HOLD;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    state_d = S_ISSUE;
                    done_d  = 1'b1;
                    case (bus.instr_op)
                        3'b001: begin
                            fx_d = F_CLEAR;
                            fy_d = F_CLEAR;
                            fz_d = F_CLEAR;
                        end
                        3'b010: begin
                            fx_d   = F_LOAD;
                            data_d = bus.instr_operand;
                        end
                        3'b011: begin
                            fy_d   = F_LOAD;
                            data_d = bus.instr_operand;
                        end
                        3'b100, 3'b101: begin
                            // rem counts steps left after this one; count 0 wraps to 2**CNT_W-1
                            state_d = S_SHIFT;
                            fy_d    = (bus.instr_op == 3'b100) ? F_SL : F_SR;
                            rem_d   = bus.instr_count - CNT_W'(1);
                            done_d  = (bus.instr_count == CNT_W'(1));
                        end
                        3'b110:  fz_d  = F_LOAD;
                        3'b111:  err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ISSUE: state_d = S_IDLE;
            S_SHIFT: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    fy_d   = fy_q;
                    rem_d  = rem_q - CNT_W'(1);
                    done_d = (rem_q == CNT_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fx_q    <= F_CLEAR;
            fy_q    <= F_CLEAR;
            fz_q    <= F_CLEAR;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fz_q    <= fz_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE) && !rst;
    assign bus.func_x      = fx_q;
    assign bus.func_y      = fy_q;
    assign bus.func_z      = fz_q;
    assign bus.data_out    = data_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.dbg_state   = state_q;
endmodule
